benes_cfg_sequencer: RTL and testbench
======================================

Name: benes_cfg_sequencer

Overview:
- Sequences switch-control words from a configuration memory into the 32-port Benes permutation network, one word per cycle.
- Tracks network pipeline latency and strobes the output-capture logic when each permuted result is valid.
- Signals completion and reports a cycle count for performance logging.
- Sits between the layer config RAM (L1..L5 schedules) and the Benes network / output register bank.

Parameters:
- SW, 10, switch-control word width (s bus)
- DEPTH, 32, maximum configuration steps per run
- AW, 5, config-memory address width (log2 DEPTH)
- LAT, 9, cycles from s_valid to valid network output
- CW, 32, cycle-counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- cfg_len  in  AW+1  number of steps for this run; sampled with start
- abort  in  1  synchronous cancel of the current run
- hold  in  1  back-pressure; suspends issuing new reads
- cfg_rd  out  1  config-memory read enable
- cfg_addr  out  AW  config-memory read address
- cfg_data  in  SW  read data, valid the cycle after cfg_rd
- s_out  out  SW  switch-control word to the network
- s_valid  out  1  s_out carries a new word this cycle
- cap_valid  out  1  network output for step cap_idx is valid this cycle
- cap_idx  out  AW  step index of the current capture
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of a run
- cycle_count  out  CW  cycles from start accept to done, inclusive

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal counters, valid shift register, and latched length are cleared.
- States:
  - IDLE: start=1 latches L = min(cfg_len, DEPTH) and clears cycle_count to 1. Next state is RUN, or DONE if L=0.
  - RUN: each cycle with hold=0, cfg_rd=1, cfg_addr=issue_cnt, and issue_cnt increments. With hold=1, cfg_rd=0 and the address holds. After the read with issue_cnt=L-1 is issued, go to DRAIN.
  - DRAIN: wait until cap_cnt=L, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Data path timing:
  - A read issued in cycle c is registered at the end of c+1, so s_out=cfg_data and s_valid=1 in cycle c+2.
  - s_valid feeds an LAT-deep shift register. Its tap drives cap_valid exactly LAT cycles after s_valid.
  - cap_idx = cap_cnt, which increments on every cap_valid.
  - s_out holds its last value when s_valid=0.
- Timing, start at T0 with hold=0 and length L:
  - cfg_rd is high in cycles T0+1..T0+L.
  - s_valid is high in T0+3..T0+L+2.
  - cap_valid is high in T0+3+LAT..T0+L+2+LAT.
  - done is high in cycle T0+L+3+LAT.
- cycle_count:
  - Increments every cycle while state≠IDLE; the value in the DONE cycle is final.
  - Holds in IDLE until the next accepted start.
  - Saturates at all-ones.
- busy is high in RUN and DRAIN only.
- Boundary conditions:
  - start outside IDLE is ignored.
  - cfg_len > DEPTH is clamped to DEPTH.
  - cfg_len = 0 goes straight to DONE: done pulses at T0+1 and no cfg_rd is issued.
  - abort has priority over all other inputs. In any non-IDLE state, the next state is IDLE; the shift register, counters, cfg_rd, s_valid, and cap_valid clear at the next edge; done is not pulsed; cycle_count freezes.
  - hold during DRAIN has no effect.
  - hold and the last issue in the same cycle: the issue does not occur and the state stays RUN.
  - rst_n deasserting mid-run lands in IDLE with no residual strobes.

Test Plan:
- L=32, hold=0, LAT=9, start at T0 -> 32 cfg_rd with cfg_addr 0..31 consecutively; s_out equals mem[k] at T0+3+k; cap_idx 0..31 at T0+12..T0+43; done at T0+44; cycle_count=45.
- L=4, hold=1 for 3 cycles after the second read -> cfg_addr sequence 0,1,(stall×3),2,3; cap_valid gaps mirror the s_valid gaps; done at T0+4+3+LAT+3=T0+19; cycle_count=20.
- cfg_len=0 -> no cfg_rd, s_valid, or cap_valid; done at T0+1; cycle_count=2.
- cfg_len=40 -> clamped to 32; last cfg_addr=31; exactly 32 cap_valid pulses.
- abort at T0+6 of an L=32 run -> IDLE at T0+7; no further cfg_rd, s_valid, or cap_valid; no done; a new start at T0+9 runs cleanly from address 0.
- rst_n low during DRAIN, or start pulsed while busy -> outputs go to 0 asynchronously; the start is ignored and no second run begins.

Source files
------------

// File: rtl/benes_cfg_sequencer_if.sv
// Bundle between the Benes configuration sequencer and its environment
// (run control, config RAM read port, network control, capture strobes).
//
// master: run-control host plus config RAM. It drives start/cfg_len/abort/hold
//         and cfg_data, and observes everything else.
// slave : the sequencer. It drives cfg_rd/cfg_addr, s_out/s_valid,
//         cap_valid/cap_idx, busy/done and cycle_count.
interface benes_cfg_sequencer_if #(
    parameter int unsigned SW = 10,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 32
);
    logic          start;
    logic [AW:0]   cfg_len;
    logic          abort;
    logic          hold;
    logic          cfg_rd;
    logic [AW-1:0] cfg_addr;
    logic [SW-1:0] cfg_data;
    logic [SW-1:0] s_out;
    logic          s_valid;
    logic          cap_valid;
    logic [AW-1:0] cap_idx;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_count;

    modport master (
        output start, cfg_len, abort, hold, cfg_data,
        input  cfg_rd, cfg_addr, s_out, s_valid, cap_valid, cap_idx, busy, done, cycle_count
    );

    modport slave (
        input  start, cfg_len, abort, hold, cfg_data,
        output cfg_rd, cfg_addr, s_out, s_valid, cap_valid, cap_idx, busy, done, cycle_count
    );
endinterface

// File: rtl/benes_cfg_sequencer.sv
// Benes network configuration sequencer.
// Streams up to DEPTH switch-control words from the config RAM into the
// Benes network, one per cycle, tracks the LAT-cycle network latency to
// strobe the output capture bank, then pulses done with a cycle count.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - benes_cfg_sequencer_if.slave:
//            start/cfg_len/abort/hold  run control in
//            cfg_rd/cfg_addr/cfg_data  config RAM read port (1-cycle read latency)
//            s_out/s_valid             switch-control word to the network
//            cap_valid/cap_idx         capture strobe and step index
//            busy/done/cycle_count     status and performance count
module benes_cfg_sequencer #(
    parameter int unsigned SW    = 10,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned LAT   = 9,
    parameter int unsigned CW    = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    benes_cfg_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CntOne   = (AW + 1)'(1);
    localparam logic [CW-1:0] CycMax   = {CW{1'b1}};
    // The accept cycle itself is cycle 1, so the first RUN cycle reads 2.
    localparam logic [CW-1:0] CycStart = CW'(2);

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_in;
    logic [AW:0]   issue_cnt_q;
    logic [AW:0]   cap_cnt_q, cap_cnt_d;
    logic          rd_q;
    logic [SW-1:0] s_out_q;
    logic          s_valid_q;
    logic [LAT-1:0] sr_q;
    logic [CW-1:0] cyc_q;
    logic          accept, abort_act;
    logic          cfg_rd, cap_valid, busy, done;

    assign len_in    = (bus.cfg_len > DepthW) ? DepthW : bus.cfg_len;
    assign abort_act = bus.abort && (state_q != StIdle);
    assign accept    = (state_q == StIdle) && bus.start && !bus.abort;
    assign cap_valid = sr_q[LAT-1];
    assign cap_cnt_d = cap_cnt_q + (cap_valid ? CntOne : '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over everything, including start in IDLE
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (bus.start) state_d = (len_in == '0) ? StDone : StRun;
                // A held cycle never issues, so the last read waits for hold to drop
                StRun:   if (!bus.hold && (issue_cnt_q == len_q - CntOne)) state_d = StDrain;
                // Look at the post-increment count so done lands right after the last capture
                StDrain: if (cap_cnt_d == len_q) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output decode
    always_comb begin
        cfg_rd = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            StRun: begin
                busy   = 1'b1;
                cfg_rd = !bus.hold && !bus.abort;
            end
            StDrain: busy = 1'b1;
            StDone:  done = !bus.abort;
            default: ;
        endcase
    end

    // Datapath: issue/capture counters, read-data pipeline, latency line, cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            rd_q        <= 1'b0;
            s_out_q     <= '0;
            s_valid_q   <= 1'b0;
            sr_q        <= '0;
            cyc_q       <= '0;
        end else if (abort_act) begin
            // Flush everything in flight; cycle_count and s_out keep their values
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            rd_q        <= 1'b0;
            s_valid_q   <= 1'b0;
            sr_q        <= '0;
        end else begin
            if (accept) begin
                len_q       <= len_in;
                issue_cnt_q <= '0;
                cap_cnt_q   <= '0;
                cyc_q       <= CycStart;
            end else begin
                if (cfg_rd) begin
                    issue_cnt_q <= issue_cnt_q + CntOne;
                end
                cap_cnt_q <= cap_cnt_d;
                // DONE always returns to IDLE, so only RUN/DRAIN advance the count
                if (busy && (cyc_q != CycMax)) begin
                    cyc_q <= cyc_q + CW'(1);
                end
            end
            rd_q      <= cfg_rd;
            s_valid_q <= rd_q;
            if (rd_q) begin
                s_out_q <= bus.cfg_data;
            end
            sr_q <= (sr_q << 1) | LAT'(s_valid_q);
        end
    end

    assign bus.cfg_rd      = cfg_rd;
    assign bus.cfg_addr    = issue_cnt_q[AW-1:0];
    assign bus.s_out       = s_out_q;
    assign bus.s_valid     = s_valid_q;
    assign bus.cap_valid   = cap_valid;
    assign bus.cap_idx     = cap_cnt_q[AW-1:0];
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.cycle_count = cyc_q;

endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// Directed self-checking bench for benes_cfg_sequencer.
// Each run is described by the cycles (relative to the start cycle T0) in
// which reads are expected to issue; s_valid, s_out, cap_valid and cap_idx
// expectations follow from the fixed +2 and +2+LAT offsets.
module tb_benes_cfg_sequencer;
    localparam int SW    = 10;
    localparam int AW    = 5;
    localparam int CW    = 32;
    localparam int LAT   = 9;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    benes_cfg_sequencer_if #(.SW(SW), .AW(AW), .CW(CW)) bus ();

    benes_cfg_sequencer #(
        .SW   (SW),
        .DEPTH(DEPTH),
        .AW   (AW),
        .LAT  (LAT),
        .CW   (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Config RAM model: one-cycle registered read
    logic [SW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.cfg_rd) bus.cfg_data <= mem[bus.cfg_addr];
    end

    int vectors     = 0;
    int miscompares = 0;
    int iss [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd"},   64'(bus.cfg_rd),    64'd0);
        chk({tag, "_sv"},   64'(bus.s_valid),   64'd0);
        chk({tag, "_cap"},  64'(bus.cap_valid), 64'd0);
        chk({tag, "_done"}, 64'(bus.done),      64'd0);
        chk({tag, "_busy"}, 64'(bus.busy),      64'd0);
    endtask

    // Called at posedge+1 of T0 with the DUT idle. Returns at posedge+1 of T0+done_n+3.
    task automatic run(input int len_in, input int nl, input int done_n,
                       input int h1_lo, input int h1_hi, input int h2_lo, input int h2_hi,
                       input int restart_n);
        logic       e_rd, e_sv, e_cap;
        int         e_addr, e_sidx, e_cidx;
        bus.start   = 1'b1;
        bus.cfg_len = 6'(len_in);
        #1;
        chk("t0_busy", 64'(bus.busy), 64'd0);
        next();
        bus.start = 1'b0;
        for (int n = 1; n <= done_n + 2; n++) begin
            bus.hold    = (n >= h1_lo && n <= h1_hi) || (n >= h2_lo && n <= h2_hi);
            bus.start   = (n == restart_n);
            bus.cfg_len = 6'd2;
            #1;
            e_rd = 1'b0; e_sv = 1'b0; e_cap = 1'b0;
            e_addr = 0; e_sidx = 0; e_cidx = 0;
            for (int k = 0; k < nl; k++) begin
                if (iss[k] == n)           begin e_rd  = 1'b1; e_addr = k; end
                if (iss[k] + 2 == n)       begin e_sv  = 1'b1; e_sidx = k; end
                if (iss[k] + 2 + LAT == n) begin e_cap = 1'b1; e_cidx = k; end
            end
            chk("cfg_rd", 64'(bus.cfg_rd), 64'(e_rd));
            if (e_rd) chk("cfg_addr", 64'(bus.cfg_addr), 64'(e_addr));
            chk("s_valid", 64'(bus.s_valid), 64'(e_sv));
            if (e_sv) chk("s_out", 64'(bus.s_out), 64'(mem[e_sidx]));
            chk("cap_valid", 64'(bus.cap_valid), 64'(e_cap));
            if (e_cap) chk("cap_idx", 64'(bus.cap_idx), 64'(e_cidx));
            chk("done", 64'(bus.done), 64'(n == done_n));
            chk("busy", 64'(bus.busy), 64'(n < done_n));
            if (n >= done_n) chk("cycle_count", 64'(bus.cycle_count), 64'(done_n + 1));
            next();
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = SW'((i * 29 + 7) % 1024);
        bus.start   = 1'b0;
        bus.cfg_len = '0;
        bus.abort   = 1'b0;
        bus.hold    = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk_quiet("reset");
        chk("reset_addr",  64'(bus.cfg_addr),    64'd0);
        chk("reset_sout",  64'(bus.s_out),       64'd0);
        chk("reset_cidx",  64'(bus.cap_idx),     64'd0);
        chk("reset_count", 64'(bus.cycle_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next();

        // Full-length run: done at T0+44, count 45
        for (int k = 0; k < 32; k++) iss[k] = k + 1;
        run(32, 32, 44, 0, -1, 0, -1, 0);

        // L=4 with 3 stall cycles after the second read, and hold during DRAIN
        iss[0] = 1; iss[1] = 2; iss[2] = 6; iss[3] = 7;
        run(4, 4, 19, 3, 5, 12, 13, 0);

        // Zero length: done at T0+1, count 2, no strobes
        run(0, 0, 1, 0, -1, 0, -1, 0);

        // Clamp: 40 behaves as 32
        for (int k = 0; k < 32; k++) iss[k] = k + 1;
        run(40, 32, 44, 0, -1, 0, -1, 0);

        // Hold coinciding with the last issue delays it by one cycle
        iss[0] = 1; iss[1] = 3;
        run(2, 2, 15, 2, 2, 0, -1, 0);

        // start pulsed in DRAIN is ignored; no second run follows
        iss[0] = 1; iss[1] = 2; iss[2] = 3; iss[3] = 4;
        run(4, 4, 16, 0, -1, 0, -1, 5);

        // Abort at T0+6 of an L=32 run
        bus.start   = 1'b1;
        bus.cfg_len = 6'd32;
        next();
        bus.start = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            #1;
            chk("ab_rd",   64'(bus.cfg_rd),   64'd1);
            chk("ab_addr", 64'(bus.cfg_addr), 64'(n - 1));
            next();
        end
        bus.abort = 1'b1;
        #1;
        chk("ab_done6", 64'(bus.done), 64'd0);
        next();
        bus.abort = 1'b0;
        for (int n = 7; n <= 8; n++) begin
            #1;
            chk_quiet("ab_idle");
            chk("ab_count", 64'(bus.cycle_count), 64'd7);
            next();
        end
        // Restart at T0+9; leftover strobes from the aborted run would appear here
        iss[0] = 1; iss[1] = 2; iss[2] = 3; iss[3] = 4;
        run(4, 4, 16, 0, -1, 0, -1, 0);

        // Asynchronous reset during DRAIN
        bus.start   = 1'b1;
        bus.cfg_len = 6'd32;
        next();
        bus.start = 1'b0;
        for (int n = 1; n < 36; n++) next();
        #1;
        chk("rs_pre_busy", 64'(bus.busy),      64'd1);
        chk("rs_pre_cap",  64'(bus.cap_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_async");
        chk("rst_count", 64'(bus.cycle_count), 64'd0);
        chk("rst_cidx",  64'(bus.cap_idx),     64'd0);
        chk("rst_sout",  64'(bus.s_out),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            next();
            #1;
            chk_quiet("post_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
